// File: rtl/window_buffer.sv
// Streaming NxN sliding-window generator: buffers the previous N-1 raster rows and
// emits every complete stride-1 window as a packed bus, with valid/ready on both sides.
module window_buffer #(
    parameter int N           = 3,
    parameter int BitSize     = 4,
    parameter int ImageWidth  = 8,
    parameter int ImageHeight = 8
) (
    input  logic                      clk,
    input  logic                      res_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [BitSize-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BitSize*N*N-1:0]    out_data,
    output logic                      out_last
);

    localparam int CW = (ImageWidth  > 1) ? $clog2(ImageWidth)  : 1;
    localparam int RW = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(ImageWidth - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(N - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ImageHeight - 1);
    localparam logic [RW-1:0] ROW_FILL  = RW'(N - 2);

    typedef enum logic {FILL, STREAM} state_t;

    state_t        state, state_next;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          emit;
    logic          frame_end;

    logic signed [BitSize-1:0] line_mem [ImageWidth][N-1];
    logic signed [BitSize-1:0] win_p0   [N][N];
    logic signed [BitSize-1:0] win_next [N][N];
    logic [BitSize*N*N-1:0]    packed_next;

    logic                      vld_p1;
    logic                      last_p1;
    logic [BitSize*N*N-1:0]    data_p1;

    assign in_ready  = !vld_p1 || out_ready;
    assign accept    = in_valid && in_ready;
    assign frame_end = (row == ROW_LAST) && (col == COL_LAST);
    assign emit      = accept && (state == STREAM) && (col >= COL_FIRST);

    // Window after this pixel: shift left one column, append the new column
    // built from the line buffers (older rows) on top of the incoming pixel.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N - 1; c++) begin
                win_next[r][c] = win_p0[r][c+1];
            end
        end
        for (int r = 0; r < N - 1; r++) begin
            win_next[r][N-1] = line_mem[col][r];
        end
        win_next[N-1][N-1] = in_data;
    end

    always_comb begin
        packed_next = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                packed_next[BitSize*(N*N-1-(r*N+c)) +: BitSize] = win_next[r][c];
            end
        end
    end

    // p0: window shift register and line buffers (data only, no reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    win_p0[r][c] <= win_next[r][c];
                end
            end
            for (int k = 0; k < N - 1; k++) begin
                line_mem[col][k] <= win_next[k+1][N-1];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (accept && row == ROW_FILL && col == COL_LAST) state_next = STREAM;
            STREAM:  if (accept && frame_end) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= FILL;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // p1: output register; a drain and a new window in the same cycle keep it full
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            data_p1 <= '0;
        end else if (emit) begin
            vld_p1  <= 1'b1;
            last_p1 <= frame_end;
            data_p1 <= packed_next;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_last  = last_p1;
    assign out_data  = data_p1;

endmodule

// File: tb/tb_window_buffer.sv
// Randomized bench for window_buffer (N=3, 4-bit pixels, 4x4 frames) checked against
// a frame-image reference model that derives each expected window from pixel coordinates.
module tb_window_buffer;

    localparam int N  = 3;
    localparam int B  = 4;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int OW = B * N * N;

    logic          clk = 1'b0;
    logic          res_n;
    logic          in_valid;
    logic          in_ready;
    logic [B-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;

    window_buffer #(.N(N), .BitSize(B), .ImageWidth(W), .ImageHeight(H)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } win_t;

    win_t          exp_q[$];
    logic [B-1:0]  img [H][W];
    int            pix_idx;
    int            checks = 0;
    int            errors = 0;
    int            pop_count;
    logic [OW-1:0] first_data, last_data;
    logic          last_flag;
    logic          hold_prev;
    logic [OW-1:0] held_data;
    logic          held_last;
    logic          rnd_ready;
    logic          stall_arm;
    int            stall_left;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: place the pixel in a frame image by raster position; a window is
    // due whenever the pixel completes an NxN block of that image.
    task automatic model_accept(input logic [B-1:0] d);
        int   r, c;
        win_t w;
        r = pix_idx / W;
        c = pix_idx % W;
        img[r][c] = d;
        if (r >= N - 1 && c >= N - 1) begin
            w.data = '0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    w.data[B*(N*N-1-(i*N+j)) +: B] = img[r-N+1+i][c-N+1+j];
            w.last = (pix_idx == W * H - 1);
            exp_q.push_back(w);
        end
        pix_idx = (pix_idx + 1) % (W * H);
    endtask

    always @(negedge clk) begin
        if (res_n) begin
            check_val("valid_vs_model", 64'(out_valid), 64'(exp_q.size() != 0));
            if (hold_prev) begin
                check_val("hold_valid", 64'(out_valid), 64'd1);
                check_val("hold_data", 64'(out_data), 64'(held_data));
                check_val("hold_last", 64'(out_last), 64'(held_last));
            end
            if (out_valid && exp_q.size() != 0) begin
                check_val("win_data", 64'(out_data), 64'(exp_q[0].data));
                check_val("win_last", 64'(out_last), 64'(exp_q[0].last));
                if (out_ready) begin
                    if (pop_count == 0) first_data = out_data;
                    last_data = out_data;
                    last_flag = out_last;
                    pop_count++;
                    void'(exp_q.pop_front());
                end
            end
            hold_prev = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            check_val("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (in_valid && in_ready) model_accept(in_data);
        end
    end

    always @(posedge clk) begin
        #1;
        if (stall_arm && out_valid) begin
            stall_left = 5;
            stall_arm  = 1'b0;
        end
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    task automatic send_pixel(input logic [B-1:0] d, input int gap_pct);
        int budget;
        while (int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        budget   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                break;
            end
            budget++;
            if (budget > 200) begin
                check_val("in_ready_timeout", 64'(in_ready), 64'd1);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // mode 0: index mod 16, mode 1: all -1, mode 2: random
    task automatic send_frame(input int mode, input int gap_pct, input int npix);
        logic [B-1:0] d;
        for (int k = 0; k < npix; k++) begin
            case (mode)
                0:       d = B'(k);
                1:       d = '1;
                default: d = B'($urandom);
            endcase
            send_pixel(d, gap_pct);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check_val("drain_valid", 64'(out_valid), 64'd0);
        check_val("drain_queue", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        res_n = 1'b0;
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_last", 64'(out_last), 64'd0);
        check_val("rst_out_data", 64'(out_data), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        pix_idx   = 0;
        hold_prev = 1'b0;
        @(posedge clk); #1;
        res_n = 1'b1;
    endtask

    initial begin
        res_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        rnd_ready  = 1'b0;
        stall_arm  = 1'b0;
        stall_left = 0;
        pix_idx    = 0;
        hold_prev  = 1'b0;
        pop_count  = 0;
        repeat (3) @(posedge clk);
        #1;
        apply_reset();

        // Gap-free index stream
        pop_count = 0;
        send_frame(0, 0, W * H);
        drain();
        check_val("s1_count", 64'(pop_count), 64'd4);
        check_val("s1_first", 64'(first_data), 64'h01245689A);
        check_val("s1_last", 64'(last_data), 64'h5679ABDEF);
        check_val("s1_last_flag", 64'(last_flag), 64'd1);

        // Five-cycle downstream stall after the first window
        pop_count = 0;
        stall_arm = 1'b1;
        send_frame(0, 0, W * H);
        drain();
        check_val("s2_count", 64'(pop_count), 64'd4);
        check_val("s2_first", 64'(first_data), 64'h01245689A);
        check_val("s2_last", 64'(last_data), 64'h5679ABDEF);

        // Random input gaps and random downstream readiness
        pop_count = 0;
        rnd_ready = 1'b1;
        send_frame(0, 50, W * H);
        drain();
        rnd_ready = 1'b0;
        check_val("s3_count", 64'(pop_count), 64'd4);
        check_val("s3_first", 64'(first_data), 64'h01245689A);

        // Two frames back to back
        pop_count = 0;
        send_frame(0, 0, W * H);
        send_frame(0, 0, W * H);
        drain();
        check_val("s4_count", 64'(pop_count), 64'd8);
        check_val("s4_last", 64'(last_data), 64'h5679ABDEF);

        // Reset after pixel 6, then restart the frame
        send_frame(0, 0, 7);
        apply_reset();
        pop_count = 0;
        send_frame(0, 0, W * H);
        drain();
        check_val("s5_count", 64'(pop_count), 64'd4);
        check_val("s5_first", 64'(first_data), 64'h01245689A);

        // All pixels -1
        pop_count = 0;
        send_frame(1, 0, W * H);
        drain();
        check_val("s6_count", 64'(pop_count), 64'd4);
        check_val("s6_first", 64'(first_data), 64'hFFFFFFFFF);
        check_val("s6_last", 64'(last_data), 64'hFFFFFFFFF);

        // Random pixels, gaps and readiness over several frames
        pop_count = 0;
        rnd_ready = 1'b1;
        for (int f = 0; f < 6; f++) send_frame(2, 30, W * H);
        drain();
        rnd_ready = 1'b0;
        check_val("s7_count", 64'(pop_count), 64'd24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
